// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and byte helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_DATA_W = 32;
  localparam int MC_CNT_W  = 3;

  // mem_len encodings (bytes-1); 2'd2 is handled like a word access
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Number of bytes to move for a given mem_len code
  function automatic logic [MC_CNT_W-1:0] len_to_nbytes(input logic [1:0] len);
    logic [MC_CNT_W-1:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      LEN_W:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Select byte idx (0..3) of a little-endian word; other indices give zero
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [MC_CNT_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = w[7:0];
      3'd1:    b = w[15:8];
      3'd2:    b = w[23:16];
      3'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  // Replace byte idx (0..3) of a word; other indices leave the word untouched
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [MC_CNT_W-1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      3'd0:    r[7:0]   = b;
      3'd1:    r[15:8]  = b;
      3'd2:    r[23:16] = b;
      3'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by instruction fetch (IF) and load/store (MEM).
// One FSM moves 1, 2 or 4 bytes over the 8-bit RAM port; MEM wins any conflict.
// RAM port outputs are registered: the cycle after a grant decision is the first
// address cycle, and each read byte returns one cycle after its address.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  state_e                r_state;
  logic [MC_CNT_W-1:0]   r_cnt;       // index of the byte currently addressed
  logic [MC_CNT_W-1:0]   r_n;         // bytes in the granted access
  logic [ADDR_W-1:0]     r_base;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_asm;       // read assembly register, zero-filled at grant
  logic [ADDR_W-1:0]     r_ram_addr;
  logic                  r_ram_wr;
  logic [7:0]            r_ram_dout;
  logic [DATA_W-1:0]     r_if_data;
  logic                  r_if_done;
  logic [DATA_W-1:0]     r_mem_rdata;
  logic                  r_mem_done;

  logic [MC_CNT_W-1:0]   w_cnt_inc;
  logic [ADDR_W-1:0]     w_addr_next;
  logic                  w_last_issue;
  logic [DATA_W-1:0]     w_asm_cap;

  // Next-byte address, last-address detection and read-byte insertion
  always_comb begin
    w_cnt_inc    = r_cnt + 3'd1;
    w_addr_next  = r_base + {{(ADDR_W-MC_CNT_W){1'b0}}, w_cnt_inc};
    w_last_issue = (r_cnt == (r_n - 3'd1));
    if (r_cnt != 3'd0) begin
      // ram_din now carries the byte addressed in the previous cycle
      w_asm_cap = put_byte(r_asm, r_cnt - 3'd1, ram_din);
    end else begin
      w_asm_cap = r_asm;
    end
  end

  // Controller FSM with byte counter, assembly register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_base      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_asm       <= {DATA_W{1'b0}};
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'd0;
      r_if_data   <= {DATA_W{1'b0}};
      r_if_done   <= 1'b0;
      r_mem_rdata <= {DATA_W{1'b0}};
      r_mem_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt      <= 3'd0;
          r_asm      <= {DATA_W{1'b0}};
          r_if_done  <= 1'b0;
          r_mem_done <= 1'b0;
          if (mem_req) begin
            // MEM is the older instruction, so it wins a same-cycle conflict
            r_base     <= mem_addr;
            r_n        <= len_to_nbytes(mem_len);
            r_wdata    <= mem_wdata;
            r_ram_addr <= mem_addr;
            if (mem_we) begin
              r_state    <= ST_MEM_WR;
              r_ram_wr   <= 1'b1;
              r_ram_dout <= mem_wdata[7:0];
            end else begin
              r_state    <= ST_MEM_RD;
              r_ram_wr   <= 1'b0;
              r_ram_dout <= 8'd0;
            end
          end else if (if_req) begin
            r_base     <= if_addr;
            r_n        <= 3'd4;
            r_wdata    <= {DATA_W{1'b0}};
            r_ram_addr <= if_addr;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_state    <= ST_IF_RD;
          end else begin
            r_ram_addr <= {ADDR_W{1'b0}};
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_state    <= ST_IDLE;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          r_asm      <= w_asm_cap;
          r_ram_wr   <= 1'b0;
          r_ram_dout <= 8'd0;
          if (r_cnt == r_n) begin
            // final byte arrives in this cycle; publish the assembled word
            r_state    <= ST_DONE;
            r_cnt      <= 3'd0;
            r_ram_addr <= {ADDR_W{1'b0}};
            if (r_state == ST_IF_RD) begin
              r_if_data <= w_asm_cap;
              r_if_done <= 1'b1;
            end else begin
              r_mem_rdata <= w_asm_cap;
              r_mem_done  <= 1'b1;
            end
          end else if (w_last_issue) begin
            // all addresses issued; wait one cycle for the last byte
            r_cnt      <= w_cnt_inc;
            r_ram_addr <= {ADDR_W{1'b0}};
          end else begin
            r_cnt      <= w_cnt_inc;
            r_ram_addr <= w_addr_next;
          end
        end

        ST_MEM_WR: begin
          if (w_last_issue) begin
            r_state    <= ST_DONE;
            r_cnt      <= 3'd0;
            r_ram_addr <= {ADDR_W{1'b0}};
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_mem_done <= 1'b1;
          end else begin
            r_cnt      <= w_cnt_inc;
            r_ram_addr <= w_addr_next;
            r_ram_wr   <= 1'b1;
            r_ram_dout <= pick_byte(r_wdata, w_cnt_inc);
          end
        end

        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_cnt      <= 3'd0;
          r_if_done  <= 1'b0;
          r_mem_done <= 1'b0;
          r_ram_addr <= {ADDR_W{1'b0}};
          r_ram_wr   <= 1'b0;
          r_ram_dout <= 8'd0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= 3'd0;
          r_if_done  <= 1'b0;
          r_mem_done <= 1'b0;
          r_ram_addr <= {ADDR_W{1'b0}};
          r_ram_wr   <= 1'b0;
          r_ram_dout <= 8'd0;
        end
      endcase
    end
  end

  assign ram_addr      = r_ram_addr;
  assign ram_wr        = r_ram_wr;
  assign ram_dout      = r_ram_dout;
  assign if_data       = r_if_data;
  assign if_done       = r_if_done;
  assign mem_rdata     = r_mem_rdata;
  assign mem_done      = r_mem_done;
  assign stall_req_if  = if_req & ~r_if_done;
  assign stall_req_mem = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a transaction-level reference model predicts,
// per cycle, the RAM port activity, done pulses and data words; a compare process
// checks every cycle, and directed cases pin the model with literal values.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;
  logic        stall_req_if;
  logic        stall_req_mem;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit mdl_en  = 1'b1;
  int m_free  = 0;

  // environment RAM (64 KiB window, addresses alias on the low 16 bits)
  logic [7:0]  env_ram [0:65535];
  logic [31:0] wr_log [$];
  // reference model's view of memory
  logic [7:0]  mm [0:65535];

  // per-cycle expectations, absent key = idle value
  logic [31:0] e_addr [int];
  bit          e_wr   [int];
  logic [7:0]  e_dout [int];
  bit          e_id   [int];
  logic [31:0] e_idat [int];
  bit          e_md   [int];
  logic [31:0] e_mdat [int];

  function automatic logic [7:0] init_b(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // environment RAM: read byte appears one cycle after its address
  initial begin : env
    for (int i = 0; i < 65536; i++) env_ram[i] = init_b(16'(i));
    forever begin
      @(posedge clk);
      ram_din <= env_ram[ram_addr[15:0]];
      if (ram_wr) begin
        env_ram[ram_addr[15:0]] <= ram_dout;
        wr_log.push_back(ram_addr);
      end
    end
  end

  // reference model: decides grants from the request levels and schedules expectations
  initial begin : model
    int t, n;
    logic [31:0] a, v;
    for (int i = 0; i < 65536; i++) mm[i] = init_b(16'(i));
    forever begin
      @(negedge clk);
      if (mdl_en && rst && cyc >= m_free) begin
        if (mem_req) begin
          n = (mem_len == 2'd0) ? 1 : ((mem_len == 2'd1) ? 2 : 4);
          t = cyc + 1;
          if (mem_we) begin
            for (int i = 0; i < n; i++) begin
              a = mem_addr + 32'(i);
              e_addr[t+i] = a;
              e_wr[t+i]   = 1'b1;
              e_dout[t+i] = mem_wdata[8*i +: 8];
              mm[a[15:0]] = mem_wdata[8*i +: 8];
            end
            e_md[t+n] = 1'b1;
            m_free = t + n + 1;
          end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
              a = mem_addr + 32'(i);
              e_addr[t+i] = a;
              v[8*i +: 8] = mm[a[15:0]];
            end
            e_md[t+n+1]   = 1'b1;
            e_mdat[t+n+1] = v;
            m_free = t + n + 2;
          end
        end else if (if_req) begin
          t = cyc + 1;
          v = 32'd0;
          for (int i = 0; i < 4; i++) begin
            a = if_addr + 32'(i);
            e_addr[t+i] = a;
            v[8*i +: 8] = mm[a[15:0]];
          end
          e_id[t+5]   = 1'b1;
          e_idat[t+5] = v;
          m_free = t + 6;
        end
      end
    end
  end

  // compare process: every cycle, all outputs against the model
  initial begin : compare
    logic [31:0] cur_id, cur_md, xa;
    logic        xw, xi, xm;
    logic [7:0]  xd;
    cur_id = 32'd0;
    cur_md = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_id = 32'd0;
        cur_md = 32'd0;
      end else if (chk_en) begin
        xa = e_addr.exists(cyc) ? e_addr[cyc] : 32'd0;
        xw = e_wr.exists(cyc) ? e_wr[cyc] : 1'b0;
        xd = e_dout.exists(cyc) ? e_dout[cyc] : 8'd0;
        xi = e_id.exists(cyc) ? e_id[cyc] : 1'b0;
        xm = e_md.exists(cyc) ? e_md[cyc] : 1'b0;
        if (xi) cur_id = e_idat[cyc];
        if (xm && e_mdat.exists(cyc)) cur_md = e_mdat[cyc];
        check("ram_addr", ram_addr, xa);
        check("ram_wr", {31'd0, ram_wr}, {31'd0, xw});
        check("ram_dout", {24'd0, ram_dout}, {24'd0, xd});
        check("if_done", {31'd0, if_done}, {31'd0, xi});
        check("mem_done", {31'd0, mem_done}, {31'd0, xm});
        check("if_data", if_data, cur_id);
        check("mem_rdata", mem_rdata, cur_md);
        check("stall_if", {31'd0, stall_req_if}, {31'd0, if_req & ~xi});
        check("stall_mem", {31'd0, stall_req_mem}, {31'd0, mem_req & ~xm});
      end
    end
  end

  task automatic do_if(input logic [31:0] a, output logic [31:0] d, output int c0, output int cd);
    int k;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; c0 = cyc; k = 0;
    do begin @(negedge clk); k++; end while (!if_done && k < 80);
    if (!if_done) begin
      n_tests++; n_fail++;
      $display("FAIL if_timeout addr=%h got=no_done expected=done", a);
    end
    d = if_data; cd = cyc;
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = $urandom();
  endtask

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int c0, output int cd);
    int k;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    c0 = cyc; k = 0;
    do begin @(negedge clk); k++; end while (!mem_done && k < 80);
    if (!mem_done) begin
      n_tests++; n_fail++;
      $display("FAIL mem_timeout addr=%h got=no_done expected=done", a);
    end
    rd = mem_rdata; cd = cyc;
    @(posedge clk); #1;
    mem_req = 1'b0; mem_addr = $urandom(); mem_wdata = $urandom();
    mem_we = 1'($urandom()); mem_len = 2'($urandom());
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d, d2;
    int c0, cd, c1, cd1;
    logic [7:0] o1, o2, o3;

    // reset state, with if_req pending during reset
    repeat (2) @(posedge clk); #1;
    if_req = 1'b1;
    @(negedge clk);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_data", if_data | mem_rdata, 32'd0);
    check("rst_stall_if", {31'd0, stall_req_if}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    rst = 1'b1;
    m_free = cyc;
    chk_en = 1'b1;

    // test 1 prep: write 11 22 33 44 at 0x100, then fetch
    do_mem(1'b1, 2'd3, 32'h100, 32'h44332211, d, c0, cd);
    do_if(32'h100, d, c0, cd);
    check("t1_if_data", d, 32'h44332211);
    check("t1_latency", 32'(cd - c0), 32'd6);

    // test 2: store word, then byte readback and word reload
    do_mem(1'b1, 2'd3, 32'h20, 32'hDEADBEEF, d, c0, cd);
    check("t2_latency", 32'(cd - c0), 32'd5);
    check("t2_ram", {env_ram[16'h23], env_ram[16'h22], env_ram[16'h21], env_ram[16'h20]},
          32'hDEADBEEF);
    do_mem(1'b0, 2'd3, 32'h20, 32'h0, d, c0, cd);
    check("t2_reload", d, 32'hDEADBEEF);

    // test 3: RAM[6]=00, RAM[7]=80 via half store, then byte and half loads
    do_mem(1'b1, 2'd1, 32'h6, 32'hFFFF8000, d, c0, cd);
    do_mem(1'b0, 2'd0, 32'h7, 32'h0, d, c0, cd);
    check("t3_byte", d, 32'h00000080);
    check("t3_byte_lat", 32'(cd - c0), 32'd3);
    do_mem(1'b0, 2'd1, 32'h6, 32'h0, d, c0, cd);
    check("t3_half", d, 32'h00008000);
    check("t3_half_lat", 32'(cd - c0), 32'd4);
    do_mem(1'b0, 2'd2, 32'h20, 32'h0, d, c0, cd);
    check("t3_len2_word", d, 32'hDEADBEEF);

    // test 4: same-cycle conflict, MEM first, IF decided the cycle after DONE
    fork
      do_mem(1'b0, 2'd3, 32'h20, 32'h0, d, c0, cd);
      do_if(32'h100, d2, c1, cd1);
    join
    check("t4_mem_data", d, 32'hDEADBEEF);
    check("t4_mem_lat", 32'(cd - c0), 32'd6);
    check("t4_if_data", d2, 32'h44332211);
    check("t4_if_lat", 32'(cd1 - cd), 32'd7);

    // test 5: wrapping word store
    wr_log.delete();
    do_mem(1'b1, 2'd3, 32'hFFFFFFFE, 32'h0A0B0C0D, d, c0, cd);
    check("t5_nwr", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      check("t5_a0", wr_log[0], 32'hFFFFFFFE);
      check("t5_a1", wr_log[1], 32'hFFFFFFFF);
      check("t5_a2", wr_log[2], 32'h00000000);
      check("t5_a3", wr_log[3], 32'h00000001);
    end
    check("t5_ram", {env_ram[16'h0001], env_ram[16'h0000], env_ram[16'hFFFF], env_ram[16'hFFFE]},
          32'h0A0B0C0D);

    // randomized traffic from both requesters
    fork
      begin : rnd_if
        logic [31:0] rd;
        int a0, a1;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if ($urandom_range(0, 7) == 0)
            do_if(32'hFFFFFFF8 + 32'($urandom_range(0, 7)), rd, a0, a1);
          else
            do_if(32'h200 + 32'($urandom_range(0, 255)), rd, a0, a1);
        end
      end
      begin : rnd_mem
        logic [31:0] rd;
        int a0, a1;
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_mem(1'($urandom()), 2'($urandom()), 32'h200 + 32'($urandom_range(0, 255)),
                 $urandom(), rd, a0, a1);
        end
      end
    join

    // test 6: reset during byte 1 of a word store
    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    mdl_en = 1'b0;
    o1 = mm[16'h0301]; o2 = mm[16'h0302]; o3 = mm[16'h0303];
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h300; mem_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    check("t6_b0_wr", {31'd0, ram_wr}, 32'd1);
    check("t6_b0_addr", ram_addr, 32'h300);
    @(posedge clk); #2;
    check("t6_b1_addr", ram_addr, 32'h301);
    rst = 1'b0;
    #1;
    check("t6_wr_drop", {31'd0, ram_wr}, 32'd0);
    check("t6_addr_zero", ram_addr, 32'd0);
    check("t6_dout_zero", {24'd0, ram_dout}, 32'd0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_no_done", {31'd0, mem_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    e_addr.delete(); e_wr.delete(); e_dout.delete();
    e_id.delete(); e_idat.delete(); e_md.delete(); e_mdat.delete();
    mm[16'h0300] = 8'hD4;
    m_free = cyc;
    mdl_en = 1'b1;
    chk_en = 1'b1;
    check("t6_ram", {env_ram[16'h0303], env_ram[16'h0302], env_ram[16'h0301], env_ram[16'h0300]},
          {o3, o2, o1, 8'hD4});
    repeat (3) @(negedge clk);
    check("t6_idle_done", {30'd0, if_done, mem_done}, 32'd0);
    do_if(32'h300, d, c0, cd);
    check("t6_if_data", d, {o3, o2, o1, 8'hD4});
    check("t6_if_lat", 32'(cd - c0), 32'd6);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
